// File: rtl/memory_arbiter.sv
// Two-port arbiter in front of a single-ported memory (async read, clocked write).
// Round-robin between ports, with an optional burst lock bounded by MAX_BURST grants.
module memory_arbiter #(
  parameter int LINE_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [LINE_WIDTH-1:0] addr0,
  input  logic [LINE_WIDTH-1:0] addr1,
  input  logic [LINE_WIDTH-1:0] wdata0,
  input  logic [LINE_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [LINE_WIDTH-1:0] rdata0,
  output logic [LINE_WIDTH-1:0] rdata1,
  output logic [LINE_WIDTH-1:0] mem_read_address,
  output logic [LINE_WIDTH-1:0] mem_write_address,
  output logic [LINE_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_enable,
  input  logic [LINE_WIDTH-1:0] mem_read_data
);

  localparam int               CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_CNT = CNT_W'(0);

  typedef enum logic [0:0] {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_owner;
  logic             w_owner_nxt;
  logic             r_last;
  logic             w_last_nxt;
  logic [CNT_W-1:0] r_burst_cnt;
  logic [CNT_W-1:0] w_burst_nxt;

  logic w_owner_req;
  logic w_other_req;
  logic w_gnt_any;
  logic w_winner;
  logic w_win_we;
  logic w_win_lock;

  assign w_owner_req = r_owner ? req1 : req0;
  assign w_other_req = r_owner ? req0 : req1;
  assign w_win_we    = w_winner ? we1 : we0;
  assign w_win_lock  = w_winner ? lock1 : lock0;

  assign gnt0 = w_gnt_any & ~w_winner;
  assign gnt1 = w_gnt_any & w_winner;

  // Grant selection: locked owner first (until its burst budget is spent), else round-robin.
  always_comb begin
    w_gnt_any = 1'b0;
    w_winner  = 1'b0;
    if (reset) begin
      w_gnt_any = 1'b0;
      w_winner  = 1'b0;
    end else if ((r_state == ST_LOCKED) && w_owner_req) begin
      w_gnt_any = 1'b1;
      if (r_burst_cnt < MAX_CNT) begin
        w_winner = r_owner;
      end else if (w_other_req) begin
        w_winner = ~r_owner;
      end else begin
        w_winner = r_owner;
      end
    end else if (req0 && req1) begin
      w_gnt_any = 1'b1;
      w_winner  = ~r_last;
    end else if (req0) begin
      w_gnt_any = 1'b1;
      w_winner  = 1'b0;
    end else if (req1) begin
      w_gnt_any = 1'b1;
      w_winner  = 1'b1;
    end else begin
      w_gnt_any = 1'b0;
      w_winner  = 1'b0;
    end
  end

  // Next-state logic for lock ownership, burst count and round-robin pointer.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_burst_nxt = r_burst_cnt;
    if (w_gnt_any) begin
      w_last_nxt = w_winner;
      if (w_win_lock) begin
        w_state_nxt = ST_LOCKED;
        w_owner_nxt = w_winner;
        case (r_state)
          ST_LOCKED: begin
            if (r_owner == w_winner) begin
              w_burst_nxt = (r_burst_cnt < MAX_CNT) ? (r_burst_cnt + ONE_CNT) : MAX_CNT;
            end else begin
              w_burst_nxt = ONE_CNT;
            end
          end
          ST_OPEN: begin
            w_burst_nxt = ONE_CNT;
          end
          default: begin
            w_burst_nxt = ONE_CNT;
          end
        endcase
      end else begin
        w_state_nxt = ST_OPEN;
        w_burst_nxt = ZERO_CNT;
      end
    end else begin
      w_state_nxt = r_state;
      w_burst_nxt = r_burst_cnt;
    end
  end

  // Arbitration state register; reset gives port 0 first priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_OPEN;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_burst_cnt <= ZERO_CNT;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_last      <= w_last_nxt;
      r_burst_cnt <= w_burst_nxt;
    end
  end

  // Memory port mux: winner's request, or port 0's fields with writes disabled when idle.
  always_comb begin
    mem_read_address  = addr0;
    mem_write_address = addr0;
    mem_write_data    = wdata0;
    mem_write_enable  = 1'b0;
    if (w_gnt_any) begin
      if (w_winner) begin
        mem_read_address  = addr1;
        mem_write_address = addr1;
        mem_write_data    = wdata1;
      end else begin
        mem_read_address  = addr0;
        mem_write_address = addr0;
        mem_write_data    = wdata0;
      end
      mem_write_enable = w_win_we;
    end else begin
      mem_write_enable = 1'b0;
    end
  end

  // Read response registers; rdata holds between responses.
  always_ff @(posedge clock) begin
    if (reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= {LINE_WIDTH{1'b0}};
      rdata1  <= {LINE_WIDTH{1'b0}};
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (gnt0 & ~we0) begin
        rdata0 <= mem_read_data;
      end
      if (gnt1 & ~we1) begin
        rdata1 <= mem_read_data;
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized self-checking bench for memory_arbiter against a rule-level reference model
// and a shadow copy of the memory contents.
module tb_memory_arbiter;
  localparam int LW = 8;
  localparam int MB = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic          req0, req1, lock0, lock1, we0, we1;
  logic [LW-1:0] addr0, addr1, wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [LW-1:0] rdata0, rdata1;
  logic [LW-1:0] mem_read_address, mem_write_address, mem_write_data, mem_read_data;
  logic          mem_write_enable;

  memory_arbiter #(.LINE_WIDTH(LW), .MAX_BURST(MB)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_read_address(mem_read_address), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_enable(mem_write_enable),
    .mem_read_data(mem_read_data)
  );

  // Memory block: async read, clocked write.
  logic [LW-1:0] mem [0:255];
  assign mem_read_data = mem[mem_read_address];
  always @(posedge clock) if (mem_write_enable) mem[mem_write_address] <= mem_write_data;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Stimulus for the current cycle, per port
  bit            rst;
  bit            q[2], l[2], w[2];
  logic [LW-1:0] a[2], d[2];
  bit            granted[2];

  // Reference model state
  bit            m_locked;
  int            m_owner, m_last, m_cnt;
  logic [LW-1:0] ref_mem [0:255];
  bit            exp_rv[2];
  logic [LW-1:0] exp_rd[2];

  function automatic int pick_winner();
    if (rst) return -1;
    if (m_locked && q[m_owner]) begin
      if (m_cnt < MB) return m_owner;
      if (q[1 - m_owner]) return 1 - m_owner;
      return m_owner;
    end
    if (q[0] && q[1]) return 1 - m_last;
    if (q[0]) return 0;
    if (q[1]) return 1;
    return -1;
  endfunction

  task automatic step();
    int g;
    reset = rst;
    req0 = q[0]; lock0 = l[0]; we0 = w[0]; addr0 = a[0]; wdata0 = d[0];
    req1 = q[1]; lock1 = l[1]; we1 = w[1]; addr1 = a[1]; wdata1 = d[1];
    #1;
    g = pick_winner();
    check_val("gnt0", 32'(gnt0), 32'(g == 0));
    check_val("gnt1", 32'(gnt1), 32'(g == 1));
    check_val("mem_we", 32'(mem_write_enable), 32'((g >= 0) && w[(g >= 0) ? g : 0]));
    check_val("mem_raddr", 32'(mem_read_address), 32'((g >= 0) ? a[g] : a[0]));
    check_val("mem_waddr", 32'(mem_write_address), 32'((g >= 0) ? a[g] : a[0]));
    check_val("mem_wdata", 32'(mem_write_data), 32'((g >= 0) ? d[g] : d[0]));
    granted[0] = (g == 0);
    granted[1] = (g == 1);
    @(posedge clock);
    if (rst) begin
      m_locked = 1'b0; m_owner = 0; m_last = 1; m_cnt = 0;
      exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
      exp_rd[0] = '0;   exp_rd[1] = '0;
    end else begin
      exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
      if (g >= 0) begin
        m_last = g;
        if (l[g]) begin
          if (m_locked && m_owner == g) m_cnt = (m_cnt < MB) ? m_cnt + 1 : MB;
          else begin m_locked = 1'b1; m_owner = g; m_cnt = 1; end
        end else begin
          m_locked = 1'b0; m_cnt = 0;
        end
        if (w[g]) ref_mem[a[g]] = d[g];
        else begin exp_rv[g] = 1'b1; exp_rd[g] = ref_mem[a[g]]; end
      end
    end
    #1;
    check_val("rvalid0", 32'(rvalid0), 32'(exp_rv[0]));
    check_val("rvalid1", 32'(rvalid1), 32'(exp_rv[1]));
    check_val("rdata0", 32'(rdata0), 32'(exp_rd[0]));
    check_val("rdata1", 32'(rdata1), 32'(exp_rd[1]));
    @(negedge clock);
  endtask

  task automatic set_in(input bit rs,
                        input bit q0, input bit l0, input bit w0, input logic [LW-1:0] a0, input logic [LW-1:0] d0,
                        input bit q1, input bit l1, input bit w1, input logic [LW-1:0] a1, input logic [LW-1:0] d1);
    rst = rs;
    q[0] = q0; l[0] = l0; w[0] = w0; a[0] = a0; d[0] = d0;
    q[1] = q1; l[1] = l1; w[1] = w1; a[1] = a1; d[1] = d1;
  endtask

  // Random cycle: a pending (ungranted) request is held, otherwise a new one is drawn.
  task automatic gen(input int p_req0, input int p_req1, input int p_lock,
                     input int p_we0, input int p_we1, input int p_rst, input int amax);
    int p_req[2];
    int p_we[2];
    p_req[0] = p_req0; p_req[1] = p_req1;
    p_we[0]  = p_we0;  p_we[1]  = p_we1;
    rst = ($urandom_range(0, 99) < p_rst);
    for (int p = 0; p < 2; p++) begin
      if (!(q[p] && !granted[p])) begin
        q[p] = ($urandom_range(0, 99) < p_req[p]);
        l[p] = ($urandom_range(0, 99) < p_lock);
        w[p] = ($urandom_range(0, 99) < p_we[p]);
        a[p] = 8'($urandom_range(0, amax));
        d[p] = 8'($urandom);
      end
    end
  endtask

  int rv0_seen;

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    m_locked = 1'b0; m_owner = 0; m_last = 1; m_cnt = 0;
    exp_rv[0] = 1'b0; exp_rv[1] = 1'b0; exp_rd[0] = '0; exp_rd[1] = '0;
    granted[0] = 1'b0; granted[1] = 1'b0;
    @(negedge clock);

    // Reset, then write 0xA5 to addr 2 from port 0 and read it back from port 1
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 8'd2, 8'hA5, 1'b1, 1'b0, 1'b0, 8'd2, 8'h00);
    step(); step();
    rv0_seen = 0;
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 8'd2, 8'hA5, 1'b0, 1'b0, 1'b0, 8'd2, 8'h00);
    step();
    rv0_seen += int'(rvalid0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'd2, 8'h00);
    step();
    rv0_seen += int'(rvalid0);
    check_val("plan1_rvalid1", 32'(rvalid1), 32'd1);
    check_val("plan1_rdata1", 32'(rdata1), 32'hA5);
    check_val("plan1_rvalid0_never", 32'(rv0_seen), 32'd0);

    // Port 0 locked with both requesting: four grants to port 0, then port 1, then port 0
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 8'h00, 1'b1, 1'b0, 1'b0, 8'd3, 8'h00);
    for (int i = 0; i < 12; i++) step();

    // Port 0 locked alone: grants continue past saturation, then port 1 takes over at once
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
    for (int i = 0; i < 7; i++) step();
    q[1] = 1'b1; a[1] = 8'd3;
    step();
    check_val("sat_handover_rvalid1", 32'(rvalid1), 32'd1);

    // Reset in the middle of a locked read burst
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
    step(); step();
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 8'd2, 8'h00, 1'b1, 1'b0, 1'b0, 8'd1, 8'h00);
    step();
    check_val("rst_burst_rvalid0", 32'(rvalid0), 32'd0);
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 8'h00, 1'b1, 1'b0, 1'b0, 8'd1, 8'h00);
    step();
    check_val("rst_port0_first", 32'(rvalid0), 32'd1);

    // Both ports reading addresses 0..3 continuously, no lock
    for (int i = 0; i < 60; i++) begin gen(100, 100, 0, 0, 0, 0, 3); step(); end
    // Port 1 writing, port 0 reading behind it on addresses 0..3
    for (int i = 0; i < 300; i++) begin gen(90, 90, 0, 0, 100, 0, 3); step(); end
    // General mix with locks and occasional resets
    for (int i = 0; i < 800; i++) begin gen(70, 70, 50, 40, 40, 3, 7); step(); end
    for (int i = 0; i < 300; i++) begin gen(95, 30, 80, 20, 50, 1, 255); step(); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares one memory instance (async read port, clocked write port) between two requesters, port 0 and port 1.
- At most one access is issued to the memory per cycle.
- Round-robin arbitration, with an optional bounded burst lock per requester.
- Read data is registered and returned one cycle after the grant.
- Sits between the core's fetch/load-store units and the memory block.

Parameters:
- LINE_WIDTH, 8, width of address and data words.
- MAX_BURST, 4, maximum consecutive grants to a locked requester before forced handover; must be ≥1.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req0, req1  input  1  access request from port 0/1; held until granted.
- lock0, lock1  input  1  requester wants to keep ownership for back-to-back accesses.
- we0, we1  input  1  1 = write, 0 = read; sampled with req.
- addr0, addr1  input  LINE_WIDTH  access address.
- wdata0, wdata1  input  LINE_WIDTH  write data.
- gnt0, gnt1  output  1  combinational grant, current cycle; access completes at the next edge.
- rvalid0, rvalid1  output  1  registered; read data valid, one cycle after a granted read.
- rdata0, rdata1  output  LINE_WIDTH  registered read data; holds its last value when rvalid is low.
- mem_read_address  output  LINE_WIDTH  to memory read_address.
- mem_write_address  output  LINE_WIDTH  to memory write_address.
- mem_write_data  output  LINE_WIDTH  to memory write_data.
- mem_write_enable  output  1  to memory write_enable.
- mem_read_data  input  LINE_WIDTH  from memory read_data (combinational).

Behaviour:
- Reset (sync, on edge with reset=1):
  - owner=0, last=1 (so port 0 has first priority), burst_cnt=0.
  - rvalid0/1=0, rdata0/1=0.
  - While reset is high, gnt0/1=0 and mem_write_enable=0 regardless of requests.
- State:
  - FSM OPEN: no lock held.
  - FSM LOCKED(p): port p owns the memory; burst_cnt counts consecutive grants to p.
- Grant selection, OPEN:
  - Single requester: that requester wins.
  - Both requesting: winner = 1 - last (round-robin).
  - Neither requesting: no grant; last unchanged.
- Grant selection, LOCKED(p):
  - If req_p=1 and burst_cnt < MAX_BURST: p wins.
  - If burst_cnt == MAX_BURST and the other port is requesting: other port wins.
  - If the other port is idle, p may keep the grant; burst_cnt saturates at MAX_BURST.
  - If req_p=0: behave as OPEN.
- At most one gnt is high per cycle, always.
- On the edge after a grant to port g:
  - last <= g.
  - If lock_g=1 and the state was OPEN or owner≠g: go to LOCKED(g), burst_cnt=1.
  - If lock_g=1 and the state was already LOCKED(g): burst_cnt = min(burst_cnt+1, MAX_BURST).
  - If lock_g=0: go to OPEN, burst_cnt=0.
  - A lock is released only by a granted access with lock=0, or by reset.
- Memory drive:
  - mem_read_address = addr of the winner.
  - mem_write_address = addr of the winner; mem_write_data = wdata of the winner.
  - mem_write_enable = gnt & we of the winner.
  - With no grant, mem_* addresses/data = port 0 values and mem_write_enable=0.
- Read response:
  - On the edge after a granted read by g: rdata_g <= mem_read_data, rvalid_g <= 1.
  - Otherwise rvalid_g <= 0.
  - A granted write never raises rvalid.
- Simultaneous events: a read and a write to the same address in different cycles are ordered by grant order. A read in the cycle after a write to the same address returns the new data.
- Reset mid-burst: lock cleared, pending rvalid dropped, next arbitration starts fresh with port 0 priority.

Test Plan:
- Reset, then req0=1 we0=1 addr0=2 wdata0=0xA5 for one cycle; then req1=1 we1=0 addr1=2 → gnt0 in cycle 1, gnt1 in cycle 2, rvalid1=1 with rdata1=0xA5 in cycle 3, rvalid0 never set.
- Both ports continuously request reads of addr 0..3, no lock → gnt alternates 0,1,0,1…; each rvalid follows its gnt by exactly one cycle.
- lock0=1, req0 held, req1 held, MAX_BURST=4 → gnt0 for 4 consecutive cycles, then gnt1; port 0 regains the grant the cycle after, per round-robin.
- lock0=1 with req1=0 → gnt0 continues beyond 4 cycles; once req1 rises after saturation, gnt1 is granted on that same cycle.
- Assert reset during a locked burst, with a read granted in the same cycle → rvalid0=0 on the next cycle, FSM OPEN; with both ports then requesting, port 0 wins first.
- Write 0x00..0xFF cycling over addresses 0..3 from port 1 while port 0 reads behind it → every port 0 read returns the last write to that address; no cycle has gnt0 and gnt1 both high.
